// File: rtl/dac_x0504_pkg.sv
// Shared constants and types for the DACx0504 update sequencer.
package dac_x0504_pkg;

  // DACx0504 register map (downstream addresses)
  localparam logic [3:0] DAC_NOP     = 4'h0;
  localparam logic [3:0] DAC_DEVID   = 4'h1;
  localparam logic [3:0] DAC_SYNC    = 4'h2;
  localparam logic [3:0] DAC_CONFIG  = 4'h3;
  localparam logic [3:0] DAC_GAIN    = 4'h4;
  localparam logic [3:0] DAC_TRIGGER = 4'h5;
  localparam logic [3:0] DAC_BRDCAST = 4'h6;
  localparam logic [3:0] DAC_STATUS  = 4'h7;
  localparam logic [3:0] DAC_DAC0    = 4'h8;
  localparam logic [3:0] DAC_DAC1    = 4'h9;
  localparam logic [3:0] DAC_DAC2    = 4'hA;
  localparam logic [3:0] DAC_DAC3    = 4'hB;

  // TRIGGER register value that pulses LDAC
  localparam logic [15:0] LDAC_VAL = 16'h0010;

  // Local register offsets (OPB_ADDR[4] = 1)
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_PERIOD = 4'h1;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_SP0    = 4'h4;
  localparam logic [3:0] REG_SP1    = 4'h5;
  localparam logic [3:0] REG_SP2    = 4'h6;
  localparam logic [3:0] REG_SP3    = 4'h7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } sched_state_t;

  // Index of the lowest set bit of a channel mask (0 when the mask is empty)
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else if (m[3]) r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/dac_x0504_seq_ctrl_timer.sv
// Period counter with one-shot merge; emits a single-cycle registered frame_req.
module dac_seq_timer (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        one_shot,
  output logic        frame_req
);

  logic [31:0] cnt;
  logic        run;
  logic        tc;

  // The counter only runs with a non-zero period; >= tolerates PERIOD shrinking mid-count
  always_comb begin
    run = enable && (period != 32'd0);
    tc  = run && (cnt >= (period - 32'd1));
  end

  // Count PERIOD cycles, reload at terminal count, merge the one-shot request
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      cnt       <= 32'd0;
      frame_req <= 1'b0;
    end else begin
      frame_req <= tc || one_shot;
      if (!run || tc) cnt <= 32'd0;
      else            cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/dac_x0504_seq_ctrl.sv
// DACx0504 update sequencer and access arbiter: periodic shadowed channel frames
// ending in an LDAC trigger, interleaved with host pass-through accesses, with
// every downstream access spaced XFER_GAP cycles apart.
module dac_x0504_seq_ctrl
  import dac_x0504_pkg::*;
#(
  parameter int unsigned XFER_GAP   = 256,
  parameter logic [31:0] PERIOD_RST = 32'd100000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DI,
  input  logic        OPB_WE,
  input  logic        OPB_RE,
  output logic [31:0] OPB_DO,
  output logic [31:0] DIF_ADDR,
  output logic [31:0] DIF_DI,
  output logic        DIF_WE,
  output logic        DIF_RE,
  input  logic [31:0] DIF_DO,
  output logic        SEQ_BUSY
);

  localparam int unsigned      GW       = $clog2(XFER_GAP + 1);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(XFER_GAP - 1);

  // Local registers
  logic        ctrl_en, ctrl_os;
  logic [3:0]  ctrl_mask;
  logic [31:0] period_r;
  logic [15:0] sp [4];
  logic        st_ovr, st_drop;
  logic [7:0]  st_dcnt;
  logic [31:0] loc_rdata;

  // Scheduler state
  sched_state_t state;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    iss_addr;
  logic [15:0]   iss_data;
  logic          iss_trig;
  logic          pend_vld, pend_we;
  logic [3:0]    pend_addr;
  logic [15:0]   pend_data;
  logic [3:0]    rem_mask;
  logic          trig_left;
  logic [15:0]   shadow [4];

  // Combinational decode
  logic        frame_req;
  logic        loc_we, host_acc, host_avail, frame_start, frame_avail;
  logic        go, sel_host, ovr_set, drop_set;
  logic [3:0]  fmask, ch_bit, f_addr, h_addr;
  logic [1:0]  ch;
  logic        f_trig, h_we;
  logic [15:0] f_data, h_data;
  logic        unused_addr;

  assign unused_addr = &{1'b0, OPB_ADDR[31:5]};

  dac_seq_timer u_timer (
    .OPB_CLK   (OPB_CLK),
    .OPB_RST   (OPB_RST),
    .enable    (ctrl_en),
    .period    (period_r),
    .one_shot  (ctrl_os),
    .frame_req (frame_req)
  );

  // Arbitration and next-word selection; the pending host access always wins a slot
  always_comb begin
    loc_we      = OPB_WE && OPB_ADDR[4];
    host_acc    = (OPB_WE || OPB_RE) && !OPB_ADDR[4];
    host_avail  = pend_vld || host_acc;
    frame_start = frame_req && !SEQ_BUSY && (ctrl_mask != 4'h0);
    ovr_set     = frame_req && SEQ_BUSY;
    drop_set    = host_acc && pend_vld;
    fmask       = frame_start ? ctrl_mask : rem_mask;
    frame_avail = frame_start || trig_left;
    go          = (state == S_IDLE) && (gap_cnt == '0) && (host_avail || frame_avail);
    sel_host    = host_avail;
    ch          = lowest_set(fmask);
    ch_bit      = 4'b0001 << ch;
    f_trig      = (fmask == 4'h0);
    f_addr      = f_trig ? DAC_TRIGGER : {2'b10, ch};
    f_data      = f_trig ? LDAC_VAL : (frame_start ? sp[ch] : shadow[ch]);
    h_we        = pend_vld ? pend_we   : OPB_WE;
    h_addr      = pend_vld ? pend_addr : OPB_ADDR[3:0];
    h_data      = pend_vld ? pend_data : OPB_DI[15:0];
  end

  // Local register read mux and host read data path
  always_comb begin
    loc_rdata = 32'h0;
    case (OPB_ADDR[3:0])
      REG_CTRL:   loc_rdata = {24'h0, ctrl_mask, 2'b00, ctrl_os, ctrl_en};
      REG_PERIOD: loc_rdata = period_r;
      REG_STATUS: loc_rdata = {16'h0, st_dcnt, 6'h0, st_drop, st_ovr};
      REG_SP0:    loc_rdata = {16'h0, sp[0]};
      REG_SP1:    loc_rdata = {16'h0, sp[1]};
      REG_SP2:    loc_rdata = {16'h0, sp[2]};
      REG_SP3:    loc_rdata = {16'h0, sp[3]};
      default:    loc_rdata = 32'h0;
    endcase
    OPB_DO   = OPB_ADDR[4] ? loc_rdata : DIF_DO;
    DIF_ADDR = (state == S_ISSUE) ? {28'h0, iss_addr} : {28'h0, OPB_ADDR[3:0]};
    DIF_DI   = {16'h0, iss_data};
  end

  // Host-writable CTRL/PERIOD/SETPOINT registers and sticky status flags
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      ctrl_en   <= 1'b0;
      ctrl_os   <= 1'b0;
      ctrl_mask <= 4'h0;
      period_r  <= PERIOD_RST;
      sp[0]     <= 16'h0;
      sp[1]     <= 16'h0;
      sp[2]     <= 16'h0;
      sp[3]     <= 16'h0;
      st_ovr    <= 1'b0;
      st_drop   <= 1'b0;
      st_dcnt   <= 8'h0;
    end else begin
      ctrl_os <= 1'b0;
      if (loc_we) begin
        case (OPB_ADDR[3:0])
          REG_CTRL: begin
            ctrl_en   <= OPB_DI[0];
            ctrl_os   <= OPB_DI[1];
            ctrl_mask <= OPB_DI[7:4];
          end
          REG_PERIOD: period_r <= OPB_DI;
          REG_SP0:    sp[0]    <= OPB_DI[15:0];
          REG_SP1:    sp[1]    <= OPB_DI[15:0];
          REG_SP2:    sp[2]    <= OPB_DI[15:0];
          REG_SP3:    sp[3]    <= OPB_DI[15:0];
          default: ;
        endcase
      end
      if (ovr_set)
        st_ovr <= 1'b1;
      else if (loc_we && (OPB_ADDR[3:0] == REG_STATUS) && OPB_DI[0])
        st_ovr <= 1'b0;
      if (drop_set)
        st_drop <= 1'b1;
      else if (loc_we && (OPB_ADDR[3:0] == REG_STATUS) && OPB_DI[1])
        st_drop <= 1'b0;
      if (drop_set && (st_dcnt != 8'hFF))
        st_dcnt <= st_dcnt + 8'd1;
    end
  end

  // Slot scheduler: pending buffer, frame progress and registered downstream strobes
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      DIF_WE    <= 1'b0;
      DIF_RE    <= 1'b0;
      iss_addr  <= 4'h0;
      iss_data  <= 16'h0;
      iss_trig  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_we   <= 1'b0;
      pend_addr <= 4'h0;
      pend_data <= 16'h0;
      SEQ_BUSY  <= 1'b0;
      rem_mask  <= 4'h0;
      trig_left <= 1'b0;
      shadow[0] <= 16'h0;
      shadow[1] <= 16'h0;
      shadow[2] <= 16'h0;
      shadow[3] <= 16'h0;
    end else begin
      DIF_WE <= 1'b0;
      DIF_RE <= 1'b0;
      // A host access that is not issued straight away parks in the pending buffer
      if (host_acc && !pend_vld && !(go && sel_host)) begin
        pend_vld  <= 1'b1;
        pend_we   <= OPB_WE;
        pend_addr <= OPB_ADDR[3:0];
        pend_data <= OPB_DI[15:0];
      end
      if (frame_start) begin
        shadow    <= sp;
        rem_mask  <= ctrl_mask;
        trig_left <= 1'b1;
        SEQ_BUSY  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_ISSUE;
            gap_cnt <= GAP_LOAD;
            if (sel_host) begin
              DIF_WE   <= h_we;
              DIF_RE   <= !h_we;
              iss_addr <= h_addr;
              iss_data <= h_data;
              iss_trig <= 1'b0;
              if (pend_vld) pend_vld <= 1'b0;
            end else begin
              DIF_WE   <= 1'b1;
              iss_addr <= f_addr;
              iss_data <= f_data;
              iss_trig <= f_trig;
              if (f_trig) trig_left <= 1'b0;
              else        rem_mask  <= fmask & ~ch_bit;
            end
          end
        end
        S_ISSUE: begin
          // The gap counter already covers the strobe cycle, so issues land XFER_GAP apart
          state   <= S_GAP;
          gap_cnt <= gap_cnt - GW'(1);
          if (iss_trig) SEQ_BUSY <= 1'b0;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_x0504_seq_ctrl.sv
// Directed bench for dac_x0504_seq_ctrl: frames, one-shot, overrun, host
// interleave, drop handling, read pass-through and reset mid-gap.
module tb_dac_x0504_seq_ctrl;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic [31:0] OPB_ADDR = 32'h0;
  logic [31:0] OPB_DI = 32'h0;
  logic        OPB_WE = 1'b0;
  logic        OPB_RE = 1'b0;
  logic [31:0] OPB_DO;
  logic [31:0] DIF_ADDR;
  logic [31:0] DIF_DI;
  logic        DIF_WE;
  logic        DIF_RE;
  logic [31:0] DIF_DO = 32'hCAFE_0001;
  logic        SEQ_BUSY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;

  typedef struct {
    int          cyc;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t log_q[$];

  logic [3:0]  a1 [5];
  logic [15:0] d1 [5];
  logic [3:0]  a4 [6];
  logic [15:0] d4 [6];

  dac_x0504_seq_ctrl dut (
    .OPB_CLK  (OPB_CLK),
    .OPB_RST  (OPB_RST),
    .OPB_ADDR (OPB_ADDR),
    .OPB_DI   (OPB_DI),
    .OPB_WE   (OPB_WE),
    .OPB_RE   (OPB_RE),
    .OPB_DO   (OPB_DO),
    .DIF_ADDR (DIF_ADDR),
    .DIF_DI   (DIF_DI),
    .DIF_WE   (DIF_WE),
    .DIF_RE   (DIF_RE),
    .DIF_DO   (DIF_DO),
    .SEQ_BUSY (SEQ_BUSY)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  always @(posedge OPB_CLK) cyc <= cyc + 1;

  // Record every downstream strobe with the cycle it was visible in
  always @(negedge OPB_CLK) begin
    if (DIF_WE || DIF_RE) begin
      ev_t e;
      e.cyc  = cyc;
      e.we   = DIF_WE;
      e.re   = DIF_RE;
      e.addr = DIF_ADDR[3:0];
      e.data = DIF_DI[15:0];
      log_q.push_back(e);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic opb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge OPB_CLK);
    OPB_ADDR = a;
    OPB_DI   = d;
    OPB_WE   = 1'b1;
    @(negedge OPB_CLK);
    OPB_WE = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic opb_rd(input logic [31:0] a);
    @(negedge OPB_CLK);
    OPB_ADDR = a;
    OPB_RE   = 1'b1;
    @(negedge OPB_CLK);
    OPB_RE = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic rd_loc(input logic [3:0] off, input logic [31:0] exp, input string tag);
    @(negedge OPB_CLK);
    OPB_ADDR = {27'h0, 1'b1, off};
    #1;
    chk(tag, OPB_DO, exp);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge OPB_CLK);
  endtask

  initial begin
    int k;
    int k1;
    bit seen;
    a1[0] = 4'h8; a1[1] = 4'h9; a1[2] = 4'hA; a1[3] = 4'hB; a1[4] = 4'h5;
    d1[0] = 16'h1111; d1[1] = 16'h2222; d1[2] = 16'h3333; d1[3] = 16'h4444; d1[4] = 16'h0010;
    a4[0] = 4'h8; a4[1] = 4'h4; a4[2] = 4'h9; a4[3] = 4'hA; a4[4] = 4'hB; a4[5] = 4'h5;
    d4[0] = 16'h1111; d4[1] = 16'h0003; d4[2] = 16'h2222; d4[3] = 16'h3333;
    d4[4] = 16'h4444; d4[5] = 16'h0010;

    // ---- reset values
    repeat (3) @(negedge OPB_CLK);
    OPB_RST = 1'b0;
    #1;
    chk("rst_dif_we", 32'(DIF_WE), 32'd0);
    chk("rst_dif_re", 32'(DIF_RE), 32'd0);
    chk("rst_dif_di", DIF_DI, 32'h0);
    chk("rst_busy", 32'(SEQ_BUSY), 32'd0);
    rd_loc(4'h0, 32'h0, "rst_ctrl");
    rd_loc(4'h1, 32'd100000, "rst_period");
    rd_loc(4'h2, 32'h0, "rst_status");
    rd_loc(4'h4, 32'h0, "rst_sp0");

    // ---- periodic frames, mask F, PERIOD 2000
    opb_wr(32'h14, 32'h1111);
    opb_wr(32'h15, 32'h2222);
    opb_wr(32'h16, 32'h3333);
    opb_wr(32'h17, 32'h4444);
    rd_loc(4'h6, 32'h3333, "t1_sp2_read");
    opb_wr(32'h11, 32'd2000);
    log_q.delete();
    opb_wr(32'h10, 32'hF1);
    k = wr_cyc;
    wait_until(k + 5500);
    opb_wr(32'h10, 32'hF0);
    repeat (2500) @(negedge OPB_CLK);
    chk("t1_count", 32'(log_q.size()), 32'd10);
    if (log_q.size() >= 10) begin
      chk("t1_latency", 32'(log_q[0].cyc - k), 32'd2001);
      chk("t1_period", 32'(log_q[5].cyc - log_q[0].cyc), 32'd2000);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("t1_addr%0d", i), 32'(log_q[i].addr), 32'(a1[i % 5]));
        chk($sformatf("t1_data%0d", i), 32'(log_q[i].data), 32'(d1[i % 5]));
        if ((i % 5) != 0)
          chk($sformatf("t1_gap%0d", i), 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd256);
      end
    end

    // ---- one-shot, mask 0101
    log_q.delete();
    opb_wr(32'h10, 32'h52);
    k = wr_cyc;
    rd_loc(4'h0, 32'h50, "t2_ctrl_selfclear");
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge OPB_CLK);
      if (DIF_WE && (DIF_ADDR[3:0] == 4'h5)) seen = 1'b1;
    end
    chk("t2_trig_seen", 32'(seen), 32'd1);
    chk("t2_busy_at_trig", 32'(SEQ_BUSY), 32'd1);
    @(negedge OPB_CLK);
    chk("t2_busy_after_trig", 32'(SEQ_BUSY), 32'd0);
    repeat (1500) @(negedge OPB_CLK);
    chk("t2_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() >= 3) begin
      chk("t2_latency", 32'(log_q[0].cyc - k), 32'd2);
      chk("t2_a0", 32'(log_q[0].addr), 32'h8);
      chk("t2_d0", 32'(log_q[0].data), 32'h1111);
      chk("t2_a1", 32'(log_q[1].addr), 32'hA);
      chk("t2_d1", 32'(log_q[1].data), 32'h3333);
      chk("t2_a2", 32'(log_q[2].addr), 32'h5);
      chk("t2_d2", 32'(log_q[2].data), 32'h0010);
      chk("t2_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd256);
    end

    // ---- overrun with PERIOD 500
    log_q.delete();
    opb_wr(32'h11, 32'd500);
    opb_wr(32'h10, 32'hF1);
    k = wr_cyc;
    wait_until(k + 1900);
    opb_wr(32'h10, 32'hF0);
    repeat (600) @(negedge OPB_CLK);
    chk("t3_count", 32'(log_q.size()), 32'd5);
    if (log_q.size() >= 5) begin
      chk("t3_latency", 32'(log_q[0].cyc - k), 32'd501);
      chk("t3_last_addr", 32'(log_q[4].addr), 32'h5);
    end
    rd_loc(4'h2, 32'h1, "t3_ovr_set");
    opb_wr(32'h12, 32'h1);
    rd_loc(4'h2, 32'h0, "t3_ovr_clear");

    // ---- host write mid-frame
    log_q.delete();
    opb_wr(32'h10, 32'hF2);
    k = wr_cyc;
    wait_until(k + 100);
    opb_wr(32'h04, 32'h0003);
    wait_until(k + 1700);
    chk("t4_count", 32'(log_q.size()), 32'd6);
    if (log_q.size() >= 6) begin
      chk("t4_host_slot", 32'(log_q[1].cyc - log_q[0].cyc), 32'd256);
      chk("t4_frame_span", 32'(log_q[5].cyc - log_q[0].cyc), 32'd1280);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t4_addr%0d", i), 32'(log_q[i].addr), 32'(a4[i]));
        chk($sformatf("t4_data%0d", i), 32'(log_q[i].data), 32'(d4[i]));
      end
    end

    // ---- two host writes within one gap, then a host read
    log_q.delete();
    opb_wr(32'h03, 32'h0A00);
    k1 = wr_cyc;
    repeat (20) @(negedge OPB_CLK);
    opb_wr(32'h04, 32'h0001);
    opb_wr(32'h02, 32'h0002);
    wait_until(k1 + 600);
    chk("t5_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("t5_first_now", 32'(log_q[0].cyc - k1), 32'd0);
      chk("t5_a0", 32'(log_q[0].addr), 32'h3);
      chk("t5_d0", 32'(log_q[0].data), 32'h0A00);
      chk("t5_a1", 32'(log_q[1].addr), 32'h4);
      chk("t5_d1", 32'(log_q[1].data), 32'h0001);
      chk("t5_slot1", 32'(log_q[1].cyc - k1), 32'd256);
    end
    rd_loc(4'h2, 32'h0102, "t5_drop_status");
    log_q.delete();
    opb_rd(32'h01);
    k = wr_cyc;
    repeat (3) @(negedge OPB_CLK);
    #1;
    chk("t5_opb_do_passthru", OPB_DO, 32'hCAFE_0001);
    chk("t5_dif_addr_follow", DIF_ADDR, 32'h1);
    chk("t5_rd_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      chk("t5_rd_re", 32'(log_q[0].re), 32'd1);
      chk("t5_rd_we", 32'(log_q[0].we), 32'd0);
      chk("t5_rd_addr", 32'(log_q[0].addr), 32'h1);
      chk("t5_rd_when", 32'(log_q[0].cyc - k), 32'd0);
    end

    // ---- reset during GAP
    wait_until(k + 300);
    log_q.delete();
    opb_wr(32'h10, 32'hF2);
    k = wr_cyc;
    wait_until(k + 400);
    chk("t6_busy_before", 32'(SEQ_BUSY), 32'd1);
    @(negedge OPB_CLK);
    #2;
    OPB_RST = 1'b1;
    #1;
    chk("t6_rst_we", 32'(DIF_WE), 32'd0);
    chk("t6_rst_re", 32'(DIF_RE), 32'd0);
    chk("t6_rst_di", DIF_DI, 32'h0);
    chk("t6_rst_busy", 32'(SEQ_BUSY), 32'd0);
    repeat (3) @(negedge OPB_CLK);
    OPB_RST = 1'b0;
    log_q.delete();
    rd_loc(4'h0, 32'h0, "t6_ctrl");
    rd_loc(4'h1, 32'd100000, "t6_period");
    rd_loc(4'h2, 32'h0, "t6_status");
    repeat (300) @(negedge OPB_CLK);
    chk("t6_quiet", 32'(log_q.size()), 32'd0);
    opb_wr(32'h05, 32'h0010);
    k = wr_cyc;
    repeat (2) @(negedge OPB_CLK);
    chk("t6_host_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1)
      chk("t6_host_now", 32'(log_q[0].cyc - k), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
